lcb_rx_commutator: RTL and testbench

//  N-channel LCB receive commutator. Collects UART_RX bytes from each channel into
//  an on-chip packet buffer, with a timeout for short packets and sync-abort on

---
 rtl/lcb_rx_commutator.sv | 254 +++++++++++++++++++++++++
 tb/tb_lcb_rx_commutator.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_rx_commutator.sv
//==============================================================================
// Module   : lcb_rx_commutator
// Brief    : N-channel LCB receive commutator. Per-channel packet buffers are
//            drained round-robin as an 8-bit ready/valid stream.
//            Define LCB_RX_STATUS_EN to append a status beat to every packet.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module lcb_rx_commutator #(
    parameter int          N_CH    = 5,
    parameter int          BYTES   = 4,
    parameter logic [15:0] TIMEOUT = 16'd4000,
    parameter logic [7:0]  PAD     = 8'h00,
    localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*8-1:0] iData,
    input  logic [N_CH-1:0]   iValid,
    input  logic              iFrameSync,
    output logic [7:0]        oData,
    output logic [CH_W-1:0]   oChan,
    output logic [IDX_W-1:0]  oIdx,
    output logic              oLast,
    output logic              oValid,
    input  logic              iReady,
    output logic [N_CH-1:0]   oDone,
    output logic [N_CH-1:0]   oOvf
);

    localparam int CNT_W = $clog2(BYTES + 1);
`ifdef LCB_RX_STATUS_EN
    localparam int LAST_BEAT = BYTES;
`else
    localparam int LAST_BEAT = BYTES - 1;
`endif

    typedef enum logic [1:0] {CH_FILL = 2'd0, CH_READY = 2'd1, CH_DRAIN = 2'd2} ch_state_t;
    typedef enum logic [1:0] {A_IDLE = 2'd0, A_LOAD = 2'd1, A_STREAM = 2'd2} arb_state_t;

    ch_state_t [N_CH-1:0]            st_q, st_d;
    logic [N_CH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_CH-1:0][15:0]           tmr_q, tmr_d;
    logic [N_CH-1:0]                 short_q, short_d;
    logic [N_CH-1:0]                 ovf_q, ovf_d;
    logic [N_CH-1:0]                 done_q, done_d;
    logic [N_CH-1:0][BYTES-1:0][7:0] buf_q, buf_d;

    arb_state_t       arb_q, arb_d;
    logic [CH_W-1:0]  gnt_q, gnt_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [7:0]       data_q, data_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;

    logic             w_any;
    logic [CH_W-1:0]  w_pick;
    logic             w_grant;
    logic             w_fin;
    logic [CNT_W-1:0] w_nbeat;
    logic [7:0]       w_ndata;
    logic [IDX_W-1:0] w_nidx;
    logic             w_nlast;

    // Round-robin search: first READY channel at or after rr, wrapping.
    always_comb begin
        int c;
        w_any  = 1'b0;
        w_pick = '0;
        c      = 0;
        for (int i = 0; i < N_CH; i++) begin
            c = int'(rr_q) + i;
            if (c >= N_CH) c = c - N_CH;
            if (!w_any && st_q[c] == CH_READY) begin
                w_any  = 1'b1;
                w_pick = CH_W'(c);
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] base;
        st_d    = st_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        short_d = short_q;
        ovf_d   = ovf_q;
        buf_d   = buf_q;
        done_d  = '0;
        base    = '0;
        for (int k = 0; k < N_CH; k++) begin
            case (st_q[k])
                CH_FILL: begin
                    // Frame sync restarts the packet before any same-cycle byte lands.
                    base = iFrameSync ? '0 : cnt_q[k];
                    if (iFrameSync) begin
                        cnt_d[k]   = '0;
                        tmr_d[k]   = '0;
                        short_d[k] = 1'b0;
                    end
                    if (iValid[k]) begin
                        buf_d[k][base[IDX_W-1:0]] = iData[8*k +: 8];
                        cnt_d[k] = base + CNT_W'(1);
                        tmr_d[k] = '0;
                        if (int'(base) + 1 == BYTES) begin
                            st_d[k]   = CH_READY;
                            done_d[k] = 1'b1;
                        end
                    end else if (!iFrameSync && cnt_q[k] != '0) begin
                        if (TIMEOUT != 16'd0 && tmr_q[k] == TIMEOUT - 16'd1) begin
                            st_d[k]    = CH_READY;
                            short_d[k] = 1'b1;
                            done_d[k]  = 1'b1;
                        end else if (tmr_q[k] != 16'hFFFF) begin
                            tmr_d[k] = tmr_q[k] + 16'd1;
                        end
                    end
                end
                CH_READY: begin
                    if (iValid[k]) ovf_d[k] = 1'b1;
                    if (w_grant && int'(w_pick) == k) st_d[k] = CH_DRAIN;
                end
                CH_DRAIN: begin
                    if (w_fin && int'(gnt_q) == k) begin
                        st_d[k]    = CH_FILL;
                        cnt_d[k]   = '0;
                        tmr_d[k]   = '0;
                        short_d[k] = 1'b0;
`ifdef LCB_RX_STATUS_EN
                        ovf_d[k]   = 1'b0;
`endif
                    end
                    if (iValid[k]) ovf_d[k] = 1'b1;
                end
                default: st_d[k] = CH_FILL;
            endcase
        end
    end

    // Next beat contents: buffered byte, pad for a short packet, or status.
    always_comb begin
        w_nbeat = (arb_q == A_LOAD) ? '0 : beat_q + CNT_W'(1);
        w_ndata = PAD;
        if (int'(w_nbeat) < BYTES) begin
            if (w_nbeat < cnt_q[gnt_q]) w_ndata = buf_q[gnt_q][w_nbeat[IDX_W-1:0]];
        end else begin
            w_ndata = {short_q[gnt_q], ovf_q[gnt_q], 6'(cnt_q[gnt_q])};
        end
        w_nidx  = (int'(w_nbeat) < BYTES) ? w_nbeat[IDX_W-1:0] : IDX_W'(BYTES - 1);
        w_nlast = (int'(w_nbeat) == LAST_BEAT);
    end

    always_comb begin
        arb_d   = arb_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        vld_d   = vld_q;
        data_d  = data_q;
        chan_d  = chan_q;
        idx_d   = idx_q;
        last_d  = last_q;
        w_grant = 1'b0;
        w_fin   = 1'b0;
        case (arb_q)
            A_IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    gnt_d   = w_pick;
                    arb_d   = A_LOAD;
                end
            end
            A_LOAD: begin
                vld_d  = 1'b1;
                beat_d = w_nbeat;
                data_d = w_ndata;
                chan_d = gnt_q;
                idx_d  = w_nidx;
                last_d = w_nlast;
                arb_d  = A_STREAM;
            end
            A_STREAM: begin
                if (vld_q && iReady) begin
                    if (last_q) begin
                        vld_d = 1'b0;
                        w_fin = 1'b1;
                        rr_d  = (int'(gnt_q) == N_CH - 1) ? '0 : gnt_q + CH_W'(1);
                        arb_d = A_IDLE;
                    end else begin
                        beat_d = w_nbeat;
                        data_d = w_ndata;
                        idx_d  = w_nidx;
                        last_d = w_nlast;
                    end
                end
            end
            default: arb_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= {N_CH{CH_FILL}};
            cnt_q   <= '0;
            tmr_q   <= '0;
            short_q <= '0;
            ovf_q   <= '0;
            done_q  <= '0;
            buf_q   <= '0;
            arb_q   <= A_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            short_q <= short_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
            arb_q   <= arb_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign oData  = data_q;
    assign oChan  = chan_q;
    assign oIdx   = idx_q;
    assign oLast  = last_q;
    assign oValid = vld_q;
    assign oDone  = done_q;
    assign oOvf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lcb_rx_commutator.sv
//==============================================================================
// Module   : tb_lcb_rx_commutator
// Brief    : Directed self-checking bench for lcb_rx_commutator (N_CH=5, BYTES=4,
//            TIMEOUT=10); honours LCB_RX_STATUS_EN when defined.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_lcb_rx_commutator;

    localparam int BYTES = 4;
`ifdef LCB_RX_STATUS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif
    localparam int NB = BYTES + ST;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] iData = '0;
    logic [4:0]  iValid = '0;
    logic        iFrameSync = 1'b0;
    logic        iReady = 1'b0;
    logic [7:0]  oData;
    logic [2:0]  oChan;
    logic [1:0]  oIdx;
    logic        oLast;
    logic        oValid;
    logic [4:0]  oDone;
    logic [4:0]  oOvf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap_data [16];
    logic [2:0] cap_chan [16];
    logic [1:0] cap_idx  [16];
    logic       cap_last [16];

    lcb_rx_commutator #(
        .N_CH    (5),
        .BYTES   (BYTES),
        .TIMEOUT (16'd10),
        .PAD     (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iData      (iData),
        .iValid     (iValid),
        .iFrameSync (iFrameSync),
        .oData      (oData),
        .oChan      (oChan),
        .oIdx       (oIdx),
        .oLast      (oLast),
        .oValid     (oValid),
        .iReady     (iReady),
        .oDone      (oDone),
        .oOvf       (oOvf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] mask, input logic [39:0] d, input logic sync);
        iValid     = mask;
        iData      = d;
        iFrameSync = sync;
        tick();
        iValid     = '0;
        iFrameSync = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int cyc;
        cyc = 0;
        while (!oValid && cyc < 50) begin
            tick();
            cyc++;
        end
        ok = oValid;
    endtask

    // Accepts n beats with iReady held high, recording each one.
    task automatic collect(input int n, output int got);
        int cyc;
        cyc = 0;
        got = 0;
        while (got < n && cyc < 200) begin
            iReady = 1'b1;
            if (oValid) begin
                cap_data[got] = oData;
                cap_chan[got] = oChan;
                cap_idx[got]  = oIdx;
                cap_last[got] = oLast;
                got++;
            end
            tick();
            cyc++;
        end
        iReady = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({oValid, oDone, oOvf, oData, oChan, oIdx, oLast} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b done=%b ovf=%b data=%h chan=%0d idx=%0d last=%b, want all 0",
                     oValid, oDone, oOvf, oData, oChan, oIdx, oLast);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (oValid !== 1'b0 || oDone !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b done=%b, want 0 0", oValid, oDone);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  exp [5];
        logic [39:0] d;
        bit ok;
        int got;
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h04};
        for (int i = 0; i < 4; i++) begin
            d = '0;
            d[23:16] = 8'(8'hA1 + i);
            send(5'b00100, d, 1'b0);
            if (i == 2) begin
                n_tests++;
                if (oDone !== 5'd0) begin
                    n_fail++;
                    $display("FAIL basic_no_early_done: got %b, want 00000", oDone);
                end
            end
        end
        n_tests++;
        if (oDone !== 5'b00100 || oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b valid=%b, want 00100 0", oDone, oValid);
        end
        tick();
        n_tests++;
        if (oValid !== 1'b0 || oDone !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_t1: got valid=%b done=%b, want 0 00000", oValid, oDone);
        end
        tick();
        n_tests++;
        if (oValid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b, want 1 at t+2", oValid);
        end
        wait_valid(ok);
        collect(NB, got);
        n_tests++;
        if (got != NB) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats, want %0d", got, NB);
        end
        for (int b = 0; b < got; b++) begin
            n_tests++;
            if ({cap_data[b], cap_chan[b], cap_idx[b], cap_last[b]} !==
                {exp[b], 3'd2, 2'((b < BYTES) ? b : BYTES - 1), 1'(b == NB - 1)}) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got data=%h chan=%0d idx=%0d last=%b, want data=%h chan=2 idx=%0d last=%b",
                         b, cap_data[b], cap_chan[b], cap_idx[b], cap_last[b], exp[b],
                         (b < BYTES) ? b : BYTES - 1, (b == NB - 1));
            end
        end
    endtask

    task automatic test_rr_order();
        logic [39:0] d;
        logic [2:0]  order [3];
        logic [7:0]  base [3];
        logic [7:0]  e;
        bit ok;
        int got;
        order = '{3'd1, 3'd4, 3'd0};
        base  = '{8'h11, 8'h41, 8'h01};
        // Drain one ch0 packet first so the pointer lands on 1.
        for (int i = 0; i < 4; i++) send(5'b00001, {32'd0, 8'(8'hC0 + i)}, 1'b0);
        wait_valid(ok);
        collect(NB, got);
        for (int i = 0; i < 4; i++) begin
            d = '0;
            d[7:0]   = 8'(8'h01 + i);
            d[15:8]  = 8'(8'h11 + i);
            d[39:32] = 8'(8'h41 + i);
            send(5'b10011, d, 1'b0);
        end
        n_tests++;
        if (oDone !== 5'b10011) begin
            n_fail++;
            $display("FAIL rr_done: got %b, want 10011", oDone);
        end
        wait_valid(ok);
        collect(3 * NB, got);
        n_tests++;
        if (got != 3 * NB) begin
            n_fail++;
            $display("FAIL rr_count: got %0d beats, want %0d", got, 3 * NB);
        end
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (p * NB + b < got) begin
                    e = (b < BYTES) ? 8'(base[p] + b) : 8'h04;
                    n_tests++;
                    if (cap_chan[p * NB + b] !== order[p] || cap_data[p * NB + b] !== e) begin
                        n_fail++;
                        $display("FAIL rr_pkt%0d_beat%0d: got chan=%0d data=%h, want chan=%0d data=%h",
                                 p, b, cap_chan[p * NB + b], cap_data[p * NB + b], order[p], e);
                    end
                end
            end
        end
        // Pointer should now be 1: ch1 wins over ch0 when both become ready together.
        for (int i = 0; i < 4; i++) begin
            d = '0;
            d[7:0]  = 8'(8'h31 + i);
            d[15:8] = 8'(8'h51 + i);
            send(5'b00011, d, 1'b0);
        end
        wait_valid(ok);
        collect(2 * NB, got);
        n_tests++;
        if (got != 2 * NB || cap_chan[0] !== 3'd1 || cap_chan[NB] !== 3'd0 || cap_data[0] !== 8'h51) begin
            n_fail++;
            $display("FAIL rr_wrap: got beats=%0d first chan=%0d data=%h second chan=%0d, want %0d 1 51 0",
                     got, cap_chan[0], cap_data[0], cap_chan[NB], 2 * NB);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp [5];
        bit ok;
        bit early;
        int got;
        exp = '{8'h55, 8'h66, 8'h00, 8'h00, 8'h82};
        send(5'b01000, {8'h00, 8'h55, 24'd0}, 1'b0);
        send(5'b01000, {8'h00, 8'h66, 24'd0}, 1'b0);
        early = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (oDone !== 5'd0 || oValid !== 1'b0) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL timeout_early: got done/valid activity within 9 idle cycles, want none");
        end
        tick();
        n_tests++;
        if (oDone !== 5'b01000) begin
            n_fail++;
            $display("FAIL timeout_done: got %b after 10 idle cycles, want 01000", oDone);
        end
        wait_valid(ok);
        collect(NB, got);
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (b >= got || cap_data[b] !== exp[b] || cap_chan[b] !== 3'd3 || cap_last[b] !== (b == NB - 1)) begin
                n_fail++;
                $display("FAIL timeout_beat%0d: got data=%h chan=%0d last=%b (beats=%0d), want data=%h chan=3 last=%b",
                         b, cap_data[b], cap_chan[b], cap_last[b], got, exp[b], (b == NB - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5];
        logic [7:0] p_data;
        logic [1:0] p_idx;
        logic [2:0] p_chan;
        logic       p_last;
        bit ok;
        bit held;
        bit phase;
        int got;
        int cyc;
        exp = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h44};
        for (int i = 0; i < 4; i++) send(5'b00010, {24'd0, 8'(8'hB1 + i), 8'd0}, 1'b0);
        wait_valid(ok);
        n_tests++;
        if (!ok || oChan !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_grant: got valid=%b chan=%0d, want 1 1", oValid, oChan);
        end
        send(5'b00010, {24'd0, 8'hEE, 8'd0}, 1'b0);
        n_tests++;
        if (oOvf !== 5'b00010 || oData !== 8'hB1 || oValid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ovf: got ovf=%b data=%h valid=%b, want 00010 b1 1", oOvf, oData, oValid);
        end
        got = 0;
        cyc = 0;
        held = 1'b0;
        phase = 1'b1;
        p_data = '0; p_idx = '0; p_chan = '0; p_last = 1'b0;
        while (got < NB && cyc < 100) begin
            iReady = phase;
            phase = !phase;
            if (held) begin
                n_tests++;
                if ({oData, oIdx, oChan, oLast, oValid} !== {p_data, p_idx, p_chan, p_last, 1'b1}) begin
                    n_fail++;
                    $display("FAIL bp_hold: got data=%h idx=%0d chan=%0d last=%b valid=%b, want %h %0d %0d %b 1",
                             oData, oIdx, oChan, oLast, oValid, p_data, p_idx, p_chan, p_last);
                end
            end
            held = 1'b0;
            if (oValid && iReady) begin
                cap_data[got] = oData;
                got++;
            end else if (oValid) begin
                held   = 1'b1;
                p_data = oData;
                p_idx  = oIdx;
                p_chan = oChan;
                p_last = oLast;
            end
            tick();
            cyc++;
        end
        iReady = 1'b0;
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (b >= got || cap_data[b] !== exp[b]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got data=%h (beats=%0d), want %h", b, cap_data[b], got, exp[b]);
            end
        end
        n_tests++;
        if (oOvf !== ((ST == 1) ? 5'b00000 : 5'b00010)) begin
            n_fail++;
            $display("FAIL bp_ovf_after: got %b, want %b", oOvf, (ST == 1) ? 5'b00000 : 5'b00010);
        end
    endtask

    task automatic test_frame_sync();
        logic [7:0] exp [5];
        logic [4:0] want;
        bit ok;
        int got;
        exp = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'h04};
        send(5'b00001, {32'd0, 8'hC1}, 1'b0);
        send(5'b00001, {32'd0, 8'hC2}, 1'b0);
        send(5'b00001, {32'd0, 8'h77}, 1'b1);
        for (int i = 1; i < 4; i++) begin
            send(5'b00001, {32'd0, exp[i]}, 1'b0);
            want = (i == 3) ? 5'b00001 : 5'b00000;
            n_tests++;
            if (oDone !== want) begin
                n_fail++;
                $display("FAIL sync_done_byte%0d: got %b, want %b", i, oDone, want);
            end
        end
        wait_valid(ok);
        collect(NB, got);
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (b >= got || cap_data[b] !== exp[b] || cap_chan[b] !== 3'd0) begin
                n_fail++;
                $display("FAIL sync_beat%0d: got data=%h chan=%0d (beats=%0d), want %h 0",
                         b, cap_data[b], cap_chan[b], got, exp[b]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit seen;
        int got;
        for (int i = 0; i < 4; i++) send(5'b00100, {16'd0, 8'(8'hE1 + i), 16'd0}, 1'b0);
        wait_valid(ok);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        send(5'b00100, {16'd0, 8'hEE, 16'd0}, 1'b0);
        n_tests++;
        if (oOvf[2] !== 1'b1 || oValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got ovf=%b valid=%b, want bit2 set and valid 1", oOvf, oValid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({oValid, oDone, oOvf, oData} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_async: got valid=%b done=%b ovf=%b data=%h, want all 0", oValid, oDone, oOvf, oData);
        end
        tick();
        tick();
        rst = 1'b1;
        seen = 1'b0;
        iReady = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (oValid !== 1'b0) seen = 1'b1;
        end
        iReady = 1'b0;
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_residual: got oValid after reset release, want none");
        end
        for (int i = 0; i < 4; i++) send(5'b10000, {8'(8'hF1 + i), 32'd0}, 1'b0);
        wait_valid(ok);
        collect(NB, got);
        for (int b = 0; b < NB; b++) begin
            n_tests++;
            if (b >= got || cap_chan[b] !== 3'd4 ||
                cap_data[b] !== ((b < BYTES) ? 8'(8'hF1 + b) : 8'h04)) begin
                n_fail++;
                $display("FAIL rst_next_beat%0d: got data=%h chan=%0d (beats=%0d), want %h 4",
                         b, cap_data[b], cap_chan[b], got, (b < BYTES) ? 8'(8'hF1 + b) : 8'h04);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rr_order();
        test_timeout();
        test_backpressure();
        test_frame_sync();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
